// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: control word layout, opcodes and FSM states.
package mem_access_stage_pkg;

  localparam int CONTROL_REG_SIZE = 8;
  localparam int I_TYPE           = 0;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_JAL = 6'h03;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } mem_state_e;

  function automatic logic is_mem_op(input logic i_type, input logic [5:0] opcode);
    return i_type && ((opcode == OP_LW) || (opcode == OP_SW));
  endfunction

endpackage

// File: rtl/mem_ack_timer.sv
// Counts cycles spent waiting for a memory ack; saturates at ACK_TIMEOUT-1 and flags expiry.
module mem_ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = (cnt_q == CW'(ACK_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: LW/SW go through a req/ack data-memory port, everything else passes through.
// Non-memory latency 1 cycle; memory ops stall upstream from accept until the ack or timeout cycle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        valid_in,
  input  logic [31:0]                 aluData,
  input  logic [31:0]                 rtData,
  input  logic [CONTROL_REG_SIZE-1:0] control,
  input  logic [31:0]                 insn,
  input  logic [4:0]                  rdIn,
  output logic                        stall,
  output logic                        dm_req,
  output logic                        dm_we,
  output logic [31:0]                 dm_addr,
  output logic [31:0]                 dm_wdata,
  input  logic                        dm_ack,
  input  logic [31:0]                 dm_rdata,
  output logic                        valid_out,
  output logic [31:0]                 wbData,
  output logic [4:0]                  rdOut,
  output logic [31:0]                 insn_out,
  output logic [CONTROL_REG_SIZE-1:0] control_out,
  output logic                        fault
);

  mem_state_e                  state_q, state_d;
  logic                        drop_q, drop_d;
  logic                        req_q, req_d;
  logic                        we_q, we_d;
  logic [31:0]                 addr_q, addr_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic                        valid_q, valid_d;
  logic                        fault_q, fault_d;
  logic [31:0]                 wb_q, wb_d;
  logic [4:0]                  rd_q, rd_d;
  logic [31:0]                 insn_q, insn_d;
  logic [CONTROL_REG_SIZE-1:0] ctrl_q, ctrl_d;

  logic timer_clear;
  logic timer_inc;
  logic timer_expired;
  logic mem_op;
  logic misaligned;

  assign mem_op     = is_mem_op(control[I_TYPE], insn[31:26]);
  assign misaligned = ALIGN_CHECK && (aluData[1:0] != 2'b00);

  mem_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (timer_clear),
    .inc_i    (timer_inc),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    valid_d     = 1'b0;
    fault_d     = 1'b0;
    wb_d        = wb_q;
    rd_d        = rd_q;
    insn_d      = insn_q;
    ctrl_d      = ctrl_q;
    stall       = 1'b0;
    timer_clear = 1'b0;
    timer_inc   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // drop_q marks the cycle after a misaligned fault, when upstream still shows that same op
        if (valid_in && !drop_q) begin
          insn_d = insn;
          ctrl_d = control;
          rd_d   = rdIn;
          if (mem_op) begin
            stall = 1'b1;
            if (misaligned) begin
              valid_d = 1'b1;
              fault_d = 1'b1;
              wb_d    = 32'h0;
              drop_d  = 1'b1;
            end else begin
              req_d       = 1'b1;
              we_d        = (insn[31:26] == OP_SW);
              addr_d      = aluData;
              wdata_d     = rtData;
              timer_clear = 1'b1;
              state_d     = ST_WAIT_ACK;
            end
          end else begin
            valid_d = 1'b1;
            wb_d    = (insn[31:26] == OP_JAL) ? rtData : aluData;
          end
        end
      end
      ST_WAIT_ACK: begin
        timer_inc = 1'b1;
        if (dm_ack) begin
          req_d   = 1'b0;
          valid_d = 1'b1;
          wb_d    = we_q ? addr_q : dm_rdata;
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          req_d   = 1'b0;
          valid_d = 1'b1;
          fault_d = 1'b1;
          wb_d    = 32'h0;
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      wb_q    <= '0;
      rd_q    <= '0;
      insn_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      insn_q  <= insn_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign dm_req      = req_q;
  assign dm_we       = we_q;
  assign dm_addr     = addr_q;
  assign dm_wdata    = wdata_q;
  assign valid_out   = valid_q;
  assign fault       = fault_q;
  assign wbData      = wb_q;
  assign rdOut       = rd_q;
  assign insn_out    = insn_q;
  assign control_out = ctrl_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage with a planned-latency memory responder.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int TO = 4;

  logic                        clock = 1'b0;
  logic                        reset_n;
  logic                        valid_in;
  logic [31:0]                 aluData, rtData, insn;
  logic [CONTROL_REG_SIZE-1:0] control;
  logic [4:0]                  rdIn;
  logic                        stall, dm_req, dm_we, dm_ack;
  logic [31:0]                 dm_addr, dm_wdata, dm_rdata;
  logic                        valid_out, fault;
  logic [31:0]                 wbData, insn_out;
  logic [4:0]                  rdOut;
  logic [CONTROL_REG_SIZE-1:0] control_out;
  logic                        resp_ack = 1'b0;
  logic                        late_ack = 1'b0;

  assign dm_ack = resp_ack | late_ack;

  always #5 clock = ~clock;

  mem_access_stage #(.ACK_TIMEOUT(TO), .ALIGN_CHECK(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .valid_in(valid_in), .aluData(aluData),
    .rtData(rtData), .control(control), .insn(insn), .rdIn(rdIn), .stall(stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .valid_out(valid_out), .wbData(wbData),
    .rdOut(rdOut), .insn_out(insn_out), .control_out(control_out), .fault(fault)
  );

  typedef struct {
    logic [31:0]                 wb;
    logic [4:0]                  rd;
    logic [31:0]                 insn;
    logic [CONTROL_REG_SIZE-1:0] ctrl;
    logic                        flt;
  } exp_t;

  typedef struct {
    int          k;      // ack in the k-th waiting cycle (0 = zero-wait)
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output monitor
  exp_t mon_e;
  always @(negedge clock) begin
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_out", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wbData", wbData, mon_e.wb);
        chk("rdOut", {27'd0, rdOut}, {27'd0, mon_e.rd});
        chk("insn_out", insn_out, mon_e.insn);
        chk("control_out", {24'd0, control_out}, {24'd0, mon_e.ctrl});
        chk("fault", {31'd0, fault}, {31'd0, mon_e.flt});
      end
    end else if (fault !== 1'b0) begin
      chk("fault_without_valid", {31'd0, fault}, 32'd0);
    end
  end

  // Memory responder: follows the plan pushed for each issued aligned access
  initial begin
    plan_t cur;
    bit    active = 0;
    int    cnt = 0;
    dm_rdata = 32'h0;
    forever begin
      @(negedge clock);
      resp_ack = 1'b0;
      if (reset_n !== 1'b1) begin
        active = 0;
      end else begin
        if (!active && dm_req === 1'b1) begin
          if (plan_q.size() == 0) begin
            chk("unplanned_dm_req", 32'd1, 32'd0);
            cur.k = 1000; cur.rdata = 32'h0; cur.addr = dm_addr; cur.we = dm_we; cur.wdata = dm_wdata;
          end else begin
            cur = plan_q.pop_front();
          end
          active = 1;
          cnt = 0;
        end else if (active && dm_req !== 1'b1) begin
          active = 0;
        end
        if (active) begin
          chk("dm_addr", dm_addr, cur.addr);
          chk("dm_we", {31'd0, dm_we}, {31'd0, cur.we});
          chk("dm_wdata", dm_wdata, cur.wdata);
          if (cnt == cur.k) begin
            resp_ack = 1'b1;
            dm_rdata = cur.rdata;
          end else begin
            dm_rdata = $urandom;
          end
          cnt++;
        end
      end
    end
  end

  // Present one instruction and hold it while stall is high; entered and left at posedge+1
  task automatic issue(input logic v, input logic [31:0] alu, input logic [31:0] rt,
                       input logic [31:0] iw, input logic [CONTROL_REG_SIZE-1:0] ctl,
                       input logic [4:0] rd, input int k, input logic [31:0] rdata);
    exp_t  e;
    plan_t p;
    logic  mem, mis;
    int    exp_holds, holds;
    logic [5:0] op;
    op  = iw[31:26];
    mem = v && ctl[I_TYPE] && (op == OP_LW || op == OP_SW);
    mis = (alu[1:0] != 2'b00);
    exp_holds = 0;
    if (v) begin
      e.rd = rd; e.insn = iw; e.ctrl = ctl;
      if (!mem) begin
        e.wb = (op == OP_JAL) ? rt : alu; e.flt = 1'b0;
      end else if (mis) begin
        e.wb = 32'h0; e.flt = 1'b1; exp_holds = 1;
      end else begin
        p.k = k; p.rdata = rdata; p.addr = alu; p.we = (op == OP_SW); p.wdata = rt;
        plan_q.push_back(p);
        if (k < TO) begin
          e.wb = (op == OP_SW) ? alu : rdata; e.flt = 1'b0; exp_holds = 1 + k;
        end else begin
          e.wb = 32'h0; e.flt = 1'b1; exp_holds = TO;
        end
      end
      exp_q.push_back(e);
    end
    valid_in = v; aluData = alu; rtData = rt; insn = iw; control = ctl; rdIn = rd;
    holds = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clock); #1;
      if (c == 0) chk("stall_accept", {31'd0, stall}, {31'd0, mem});
      if (stall !== 1'b1) break;
      holds++;
      @(posedge clock); #1;
    end
    chk("stall_cycles", holds, exp_holds);
    @(posedge clock); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clock);
    chk("drain_pending", exp_q.size(), 32'd0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, r2, alu, iw;
    logic [CONTROL_REG_SIZE-1:0] ctl;
    int kind;
    reset_n = 1'b0; valid_in = 1'b0; aluData = 32'h0; rtData = 32'h0;
    insn = 32'h0; control = '0; rdIn = 5'd0;
    #1;
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_wbData", wbData, 32'd0);
    chk("rst_insn_out", insn_out, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed cases
    issue(1, 32'h7, 32'h9, {6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20}, 8'h00, 5'd5, 0, 32'h0);
    issue(1, 32'h100, 32'h1, {OP_LW, 5'd1, 5'd6, 16'h0100}, 8'h01, 5'd6, 2, 32'hCAFE_F00D);
    issue(1, 32'h204, 32'h55, {OP_SW, 5'd1, 5'd7, 16'h0204}, 8'h01, 5'd7, 0, 32'h0);
    issue(1, 32'h102, 32'h2, {OP_LW, 5'd1, 5'd8, 16'h0102}, 8'h01, 5'd8, 0, 32'h0);
    issue(1, 32'h300, 32'h3, {OP_LW, 5'd1, 5'd9, 16'h0300}, 8'h81, 5'd9, 9, 32'h1234_5678);
    issue(1, 32'h304, 32'h4, {OP_LW, 5'd1, 5'd10, 16'h0304}, 8'h41, 5'd10, TO - 1, 32'hBEEF_0001);

    // Randomized stream
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 7);
      r = $urandom; r2 = $urandom;
      ctl = r2[CONTROL_REG_SIZE-1:0];
      alu = r;
      case (kind)
        1: begin iw = {6'h00, r2[25:6], 6'h20}; ctl[I_TYPE] = 1'b0; end
        2: begin iw = {6'h08, r2[25:0]}; ctl[I_TYPE] = 1'b1; end
        3: begin iw = {OP_JAL, r2[25:0]}; ctl[I_TYPE] = 1'b0; end
        4, 5: begin
          iw = {OP_LW, r2[25:0]}; ctl[I_TYPE] = 1'b1;
          if ($urandom_range(0, 3) != 0) alu = {r[31:2], 2'b00};
        end
        6: begin
          iw = {OP_SW, r2[25:0]}; ctl[I_TYPE] = 1'b1;
          if ($urandom_range(0, 3) != 0) alu = {r[31:2], 2'b00};
        end
        7: begin iw = {OP_LW, r2[25:0]}; ctl[I_TYPE] = 1'b0; end
        default: iw = r2;
      endcase
      issue(kind != 0, alu, $urandom, iw, ctl, r2[31:27], $urandom_range(0, TO + 1), $urandom);
    end
    drain();

    // Reset in the middle of a pending access, then a late ack
    begin
      plan_t p;
      p.k = 1000; p.rdata = 32'h0; p.addr = 32'h400; p.we = 1'b0; p.wdata = 32'h11;
      plan_q.push_back(p);
    end
    valid_in = 1'b1; aluData = 32'h400; rtData = 32'h11; insn = {OP_LW, 26'h0400};
    control = 8'h01; rdIn = 5'd3;
    @(posedge clock); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clock);
    #2 chk("pre_rst_dm_req", {31'd0, dm_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("midrst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("midrst_wbData", wbData, 32'd0);
    chk("midrst_control_out", {24'd0, control_out}, 32'd0);
    plan_q.delete();
    @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1 late_ack = 1'b1;
    @(posedge clock); #1 late_ack = 1'b0;
    @(negedge clock);
    chk("late_ack_valid_out", {31'd0, valid_out}, 32'd0);
    chk("late_ack_dm_req", {31'd0, dm_req}, 32'd0);
    @(posedge clock); #1;
    issue(1, 32'h0000_1000, 32'h0040_0018, {OP_JAL, 26'h0100004}, 8'h00, 5'd31, 0, 32'h0);
    drain();
    chk("plan_left", plan_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
